irq_latch_arbiter: RTL and testbench

//  Synchronous interrupt-request controller built around LS74-style pending latches.

---
 rtl/irq_latch_arbiter_pkg.sv | 24 ++
 rtl/irq_latch_arbiter_if.sv | 26 ++
 rtl/irq_latch_arbiter_cell.sv | 37 +++
 rtl/irq_latch_arbiter.sv | 112 +++++++++++
 tb/tb_irq_latch_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_latch_arbiter_pkg.sv
// Shared types and helpers for the interrupt latch/arbiter block.
// Provides the FSM state type and the fixed-priority lowest-set-bit encoder.
package irq_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_t;

  // Channel 0 has the highest priority.
  function automatic logic [2:0] lowest_set(input logic [MAX_REQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_latch_arbiter_if.sv
// Request/acknowledge bus between the interrupt sources, the CPU and the arbiter.
// master drives requests, enable writes and acknowledge; slave is the arbiter.
interface irq_latch_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0] req_in;
  logic             en_we;
  logic [N_REQ-1:0] en_wdata;
  logic             n_ack;
  logic             clr_all;
  logic             n_irq;
  logic [IDW-1:0]   irq_id;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] enable;

  modport master (
    output req_in, en_we, en_wdata, n_ack, clr_all,
    input  n_irq, irq_id, pending, enable
  );

  modport slave (
    input  req_in, en_we, en_wdata, n_ack, clr_all,
    output n_irq, irq_id, pending, enable
  );
endinterface

// File: rtl/irq_latch_arbiter_cell.sv
// One request channel: edge history, active-edge detect and the pending latch.
// pend_keep is the next pending value ignoring acknowledge, used by the arbiter to spot withdrawal.
module irq_cell (
  input  logic clk,
  input  logic n_reset,
  input  logic cen,
  input  logic req,
  input  logic edge_pol,
  input  logic en_nxt,
  input  logic clr_all,
  input  logic ack_clr,
  output logic pend,
  output logic pend_keep
);

  logic prev;
  logic edge_det;
  logic pend_nxt;

  // Disable is a held clear; a fresh edge dominates clr_all and acknowledge.
  always_comb begin
    edge_det  = (req != prev) && (req == edge_pol);
    pend_keep = en_nxt && (edge_det || (!clr_all && pend));
    pend_nxt  = en_nxt && (edge_det || (!clr_all && !ack_clr && pend));
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      prev <= req;
      pend <= 1'b0;
    end else if (cen) begin
      prev <= req;
      pend <= pend_nxt;
    end
  end

endmodule

// File: rtl/irq_latch_arbiter.sv
// Interrupt controller: per-channel pending latches, enable mask, fixed-priority
// arbiter and hold-off FSM driving an active-low CPU interrupt line.
module irq_latch_arbiter
  import irq_arb_pkg::*;
#(
  parameter int               N_REQ    = 4,
  parameter int               IDW      = 2,
  parameter logic [N_REQ-1:0] EDGE_POL = '1,
  parameter int               HOLDOFF  = 2
) (
  input logic                clk,
  input logic                n_reset,
  input logic                cen,
  irq_latch_arbiter_if.slave bus
);

  irq_state_t         state, state_nxt;
  logic [N_REQ-1:0]   enable_r, en_nxt;
  logic [N_REQ-1:0]   pend, pend_keep, ack_clr;
  logic [MAX_REQ-1:0] pend_ext;
  logic [IDW-1:0]     irq_id_r, irq_id_nxt;
  logic               n_irq_r, n_irq_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  // Cells see the post-write mask so a disabled channel drops on the same edge.
  assign en_nxt  = bus.en_we ? bus.en_wdata : enable_r;
  assign ack_clr = (state == ASSERT && !bus.n_ack) ? (N_REQ'(1) << irq_id_r) : '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_cell
    irq_cell u_cell (
      .clk       (clk),
      .n_reset   (n_reset),
      .cen       (cen),
      .req       (bus.req_in[i]),
      .edge_pol  (EDGE_POL[i]),
      .en_nxt    (en_nxt[i]),
      .clr_all   (bus.clr_all),
      .ack_clr   (ack_clr[i]),
      .pend      (pend[i]),
      .pend_keep (pend_keep[i])
    );
  end

  always_comb begin
    pend_ext             = '0;
    pend_ext[N_REQ-1:0]  = pend;
  end

  always_comb begin
    state_nxt  = state;
    irq_id_nxt = irq_id_r;
    n_irq_nxt  = n_irq_r;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt  = ASSERT;
          irq_id_nxt = IDW'(lowest_set(pend_ext));
          n_irq_nxt  = 1'b0;
        end
      end
      ASSERT: begin
        // Withdrawal wins over a coincident acknowledge.
        if (!pend_keep[irq_id_r]) begin
          state_nxt = IDLE;
          n_irq_nxt = 1'b1;
        end else if (!bus.n_ack) begin
          n_irq_nxt = 1'b1;
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = CNT_W'(HOLDOFF);
          end
        end
      end
      HOLD: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        n_irq_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= IDLE;
      enable_r <= '0;
      irq_id_r <= '0;
      n_irq_r  <= 1'b1;
      cnt      <= '0;
    end else if (cen) begin
      state    <= state_nxt;
      enable_r <= en_nxt;
      irq_id_r <= irq_id_nxt;
      n_irq_r  <= n_irq_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign bus.n_irq   = n_irq_r;
  assign bus.irq_id  = irq_id_r;
  assign bus.pending = pend;
  assign bus.enable  = enable_r;

endmodule

// File: tb/tb_irq_latch_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle compared
// against a behavioural reference model through an expected-value queue.
module tb_irq_latch_arbiter;

  localparam logic [3:0] POL     = 4'b1110;
  localparam int         HOLDOFF = 2;

  logic clk = 1'b0;
  logic n_reset;
  logic cen;

  irq_latch_arbiter_if #(.N_REQ(4), .IDW(2)) bus ();

  irq_latch_arbiter #(
    .N_REQ    (4),
    .IDW      (2),
    .EDGE_POL (POL),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .cen     (cen),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: pending flags, "signalling" flag with served channel,
  // and a count of hold-off cycles still to run before arbitration resumes.
  logic [3:0]  m_prev, m_pend, m_en;
  logic [3:0]  m_ed, m_en_new, m_np;
  bit          m_active = 1'b0;
  int          m_id = 0;
  int          m_wait = 0;
  int          m_ack_ch;
  logic [10:0] exp_q[$];

  always @(posedge clk) begin
    if (!n_reset) begin
      m_prev   = bus.req_in;
      m_pend   = '0;
      m_en     = '0;
      m_active = 1'b0;
      m_id     = 0;
      m_wait   = 0;
    end else if (cen) begin
      m_en_new = bus.en_we ? bus.en_wdata : m_en;
      for (int i = 0; i < 4; i++)
        m_ed[i] = (bus.req_in[i] != m_prev[i]) && (bus.req_in[i] == POL[i]);
      m_ack_ch = (m_active && !bus.n_ack) ? m_id : -1;
      if (m_active) begin
        if (!(m_en_new[m_id] && (m_ed[m_id] || (!bus.clr_all && m_pend[m_id])))) begin
          m_active = 1'b0;
        end else if (!bus.n_ack) begin
          m_active = 1'b0;
          m_wait   = HOLDOFF;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_pend != 4'b0) begin
        m_active = 1'b1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) m_id = i;
      end
      for (int i = 0; i < 4; i++) begin
        if (!m_en_new[i])        m_np[i] = 1'b0;
        else if (m_ed[i])        m_np[i] = 1'b1;
        else if (bus.clr_all)    m_np[i] = 1'b0;
        else if (i == m_ack_ch)  m_np[i] = 1'b0;
        else                     m_np[i] = m_pend[i];
      end
      m_pend = m_np;
      m_prev = bus.req_in;
      m_en   = m_en_new;
    end
    exp_q.push_back({~m_active, 2'(m_id), m_pend, m_en});
  end

  logic [10:0] mon_exp;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("scoreboard {n_irq,id,pend,en}",
            32'({bus.n_irq, bus.irq_id, bus.pending, bus.enable}), 32'(mon_exp));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset      = 1'b0;
    cen          = 1'b1;
    bus.req_in   = 4'b0101;
    bus.en_we    = 1'b0;
    bus.en_wdata = 4'h0;
    bus.n_ack    = 1'b1;
    bus.clr_all  = 1'b0;
    step(2);
    check("rst_n_irq", 32'(bus.n_irq), 32'(1));
    check("rst_id", 32'(bus.irq_id), 32'(0));
    check("rst_pend", 32'(bus.pending), 32'(0));
    check("rst_en", 32'(bus.enable), 32'(0));

    n_reset = 1'b1; bus.en_we = 1'b1; bus.en_wdata = 4'hF;
    step(1);
    bus.en_we = 1'b0;
    check("en_write", 32'(bus.enable), 32'hF);
    step(2);
    check("no_spurious_pend", 32'(bus.pending), 32'(0));
    check("no_spurious_irq", 32'(bus.n_irq), 32'(1));

    // Rising edge on ch2, acknowledge, hold-off.
    bus.req_in = 4'b0001; step(1);
    bus.req_in = 4'b0101; step(1);
    check("t2_pend", 32'(bus.pending), 32'b0100);
    step(1);
    check("t2_n_irq", 32'(bus.n_irq), 32'(0));
    check("t2_id", 32'(bus.irq_id), 32'(2));
    bus.n_ack = 1'b0; step(1); bus.n_ack = 1'b1;
    check("t2_ack_n_irq", 32'(bus.n_irq), 32'(1));
    check("t2_ack_pend", 32'(bus.pending), 32'(0));
    step(3);

    // Falling-edge channel 0.
    bus.req_in = 4'b0100; step(1);
    check("neg_set", 32'(bus.pending), 32'b0001);
    step(1);
    check("neg_n_irq", 32'(bus.n_irq), 32'(0));
    check("neg_id", 32'(bus.irq_id), 32'(0));
    bus.n_ack = 1'b0; step(1); bus.n_ack = 1'b1;
    check("neg_ack", 32'(bus.pending), 32'(0));
    bus.req_in = 4'b0101; step(1);
    check("neg_rise_ignored", 32'(bus.pending), 32'(0));
    step(3);

    // Edge on ch1 coinciding with its acknowledge.
    bus.req_in = 4'b0111; step(2);
    check("t4_n_irq", 32'(bus.n_irq), 32'(0));
    check("t4_id", 32'(bus.irq_id), 32'(1));
    bus.req_in = 4'b0101; step(1);
    bus.req_in = 4'b0111; bus.n_ack = 1'b0; step(1); bus.n_ack = 1'b1;
    check("t4_keep_pend1", 32'(bus.pending[1]), 32'(1));
    check("t4_ack_n_irq", 32'(bus.n_irq), 32'(1));
    step(3);
    check("t4_reassert", 32'(bus.n_irq), 32'(0));
    check("t4_reassert_id", 32'(bus.irq_id), 32'(1));

    // Disable the channel being signalled.
    bus.en_we = 1'b1; bus.en_wdata = 4'b1101; step(1); bus.en_we = 1'b0;
    check("t5_withdraw", 32'(bus.n_irq), 32'(1));
    check("t5_pend", 32'(bus.pending), 32'(0));
    check("t5_en", 32'(bus.enable), 32'b1101);
    step(1);
    check("t5_idle", 32'(bus.n_irq), 32'(1));

    // No preemption: ch3 served first, then ch0.
    bus.en_we = 1'b1; bus.en_wdata = 4'hF; step(1); bus.en_we = 1'b0;
    bus.req_in = 4'b1111; step(1);
    check("t3_pend3", 32'(bus.pending), 32'b1000);
    step(1);
    check("t3_id3", 32'(bus.irq_id), 32'(3));
    bus.req_in = 4'b1110; step(1);
    check("t3_pend_both", 32'(bus.pending), 32'b1001);
    check("t3_no_preempt", 32'(bus.irq_id), 32'(3));
    bus.n_ack = 1'b0; step(1); bus.n_ack = 1'b1;
    check("t3_ack_n_irq", 32'(bus.n_irq), 32'(1));
    check("t3_ack_pend", 32'(bus.pending), 32'b0001);
    step(3);
    check("t3_next_n_irq", 32'(bus.n_irq), 32'(0));
    check("t3_next_id", 32'(bus.irq_id), 32'(0));
    bus.n_ack = 1'b0; step(1); bus.n_ack = 1'b1;
    step(3);

    // Pulse entirely inside cen=0 is not seen.
    cen = 1'b0;
    bus.req_in = 4'b1111; step(1);
    bus.req_in = 4'b1110; step(1);
    cen = 1'b1; step(2);
    check("cen_pulse_pend", 32'(bus.pending), 32'(0));
    check("cen_pulse_irq", 32'(bus.n_irq), 32'(1));

    // Random traffic: continuous cen, 1-of-4 cen, then random cen.
    for (int c = 0; c < 3000; c++) begin
      if (c < 1000)      cen = 1'b1;
      else if (c < 2000) cen = (c % 4 == 0);
      else               cen = 1'($urandom_range(0, 1));
      bus.req_in   = bus.req_in ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.en_we    = ($urandom_range(0, 15) == 0);
      bus.en_wdata = 4'($urandom | $urandom);
      bus.n_ack    = ($urandom_range(0, 2) != 0);
      bus.clr_all  = ($urandom_range(0, 31) == 0);
      n_reset      = ($urandom_range(0, 499) != 0);
      step(1);
    end

    n_reset = 1'b1; cen = 1'b1; bus.n_ack = 1'b1;
    bus.en_we = 1'b0; bus.clr_all = 1'b0;
    step(2);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
